// File: rtl/uart_transmitter_pkg.sv
// Shared definitions for the UART transmitter: FSM states, tick counter sizing
// and the parity helper used when a byte is accepted.
package uart_transmitter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam int TICK_W        = 14;
    localparam int MAX_DATA_BITS = 8;

    // One bit period is BAUD_RATE_NUMBER+1 clock cycles.
    localparam logic [TICK_W-1:0] DEFAULT_BAUD_RATE_NUMBER = 14'd20;

    // Even parity: the bit that makes the total number of ones even.
    function automatic logic even_parity(input logic [MAX_DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_transmitter_if.sv
// Host-side byte handshake plus the serial line and status flags of the transmitter.
interface uart_transmitter_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 tx;
    logic                 tx_busy;
    logic                 tx_done;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, tx, tx_busy, tx_done
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, tx, tx_busy, tx_done
    );
endinterface

// File: rtl/uart_transmitter_baud_tick.sv
// Bit-period tick generator: reload to RELOAD, count down to zero, reload again.
// The counter only moves while count_en is high, so it rests between frames.
module uart_transmitter_baud_tick
    import uart_transmitter_pkg::*;
#(
    parameter logic [TICK_W-1:0] RELOAD = DEFAULT_BAUD_RATE_NUMBER
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              count_en,
    output logic              tick,
    output logic [TICK_W-1:0] count
);

    logic [TICK_W-1:0] count_reg;
    logic [TICK_W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (load) begin
            count_next = RELOAD;
        end else if (count_en) begin
            count_next = (count_reg == '0) ? RELOAD : count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign tick  = (count_reg == '0);
    assign count = count_reg;

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: one byte per valid/ready handshake, sent as start, LSB-first
// data, optional even parity and one stop bit. All outputs except tx_ready are registered.
module uart_transmitter
    import uart_transmitter_pkg::*;
#(
    parameter logic [TICK_W-1:0] BAUD_RATE_NUMBER = DEFAULT_BAUD_RATE_NUMBER,
    parameter int                DATA_BITS        = 8,
    parameter bit                PARITY_EN        = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    uart_transmitter_if.slave bus
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    tx_state_t            state_reg, state_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic [2:0]           bit_idx_reg, bit_idx_next;
    logic                 parity_reg, parity_next;
    logic                 tx_reg, tx_next;
    logic                 busy_reg, busy_next;
    logic                 done_reg, done_next;

    logic                 handshake;
    logic                 tick;
    logic [TICK_W-1:0]    tick_count;

    assign handshake = bus.tx_valid && (state_reg == ST_IDLE);

    uart_transmitter_baud_tick #(
        .RELOAD(BAUD_RATE_NUMBER)
    ) u_baud_tick (
        .clk     (clk),
        .rst     (rst),
        .load    (handshake),
        .count_en(busy_reg),
        .tick    (tick),
        .count   (tick_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (handshake) state_next = ST_START;
            ST_START:  if (tick)      state_next = ST_DATA;
            ST_DATA:   if (tick && (bit_idx_reg == LAST_BIT)) begin
                           state_next = PARITY_EN ? ST_PARITY : ST_STOP;
                       end
            ST_PARITY: if (tick)      state_next = ST_STOP;
            ST_STOP:   if (tick)      state_next = ST_IDLE;
            default:                  state_next = ST_IDLE;
        endcase
    end

    // Byte, parity and bit index are captured only at the handshake, so later
    // changes on tx_data cannot disturb a frame already in flight.
    always_comb begin
        shift_next   = shift_reg;
        bit_idx_next = bit_idx_reg;
        parity_next  = parity_reg;
        if (handshake) begin
            shift_next   = bus.tx_data;
            parity_next  = even_parity(MAX_DATA_BITS'(bus.tx_data));
            bit_idx_next = '0;
        end else if ((state_reg == ST_DATA) && tick) begin
            shift_next   = shift_reg >> 1;
            bit_idx_next = (bit_idx_reg == LAST_BIT) ? 3'd0 : bit_idx_reg + 3'd1;
        end
    end

    // Outputs are decoded from the next state so the registered line changes on
    // the same edge as the state, one cycle after the handshake edge.
    always_comb begin
        tx_next = 1'b1;
        case (state_next)
            ST_START:  tx_next = 1'b0;
            ST_DATA:   tx_next = shift_next[0];
            ST_PARITY: tx_next = parity_next;
            default:   tx_next = 1'b1;
        endcase
        busy_next = (state_next != ST_IDLE);
        // Done marks the stop-bit cycle in which the tick counter reads zero.
        if (state_reg == ST_STOP) begin
            done_next = (tick_count == TICK_W'(1));
        end else begin
            done_next = (state_next == ST_STOP) && (BAUD_RATE_NUMBER == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg   <= '0;
            bit_idx_reg <= '0;
            parity_reg  <= 1'b0;
            tx_reg      <= 1'b1;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            shift_reg   <= shift_next;
            bit_idx_reg <= bit_idx_next;
            parity_reg  <= parity_next;
            tx_reg      <= tx_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
        end
    end

    assign bus.tx_ready = (state_reg == ST_IDLE);
    assign bus.tx       = tx_reg;
    assign bus.tx_busy  = busy_reg;
    assign bus.tx_done  = done_reg;

endmodule
